tlb_rw: RTL and testbench
=========================

Name: tlb_rw

Overview:
- Parametrised, writable, fully associative TLB; successor to the fixed-content 8-entry lookup TLB.
- Supports:
  - registered single-port lookup;
  - fill with handshake;
  - single-page invalidate (INVLPG);
  - full flush walked one entry per cycle;
  - round-robin replacement.
- Sits between the address-generation stage and the memory stage. The page-walk sequencer drives the fill port. Control logic drives invalidate and flush.

Parameters:
- NUM_ENTRIES, 8, entry count; power of two, 2..32.
- IDX_W, 3, log2(NUM_ENTRIES).
- VPN_W, 20, virtual page number width.
- PTE_W, 24, stored entry payload: {RPN[19:0], V, P, R/W, PCD}.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- LOOKUP_V  in  1  lookup request this cycle.
- LOOKUP_VPN  in  VPN_W  page to translate.
- RESULT_V  out  1  result valid; one cycle after LOOKUP_V.
- HIT  out  1  lookup matched a valid entry.
- HIT_PTE  out  PTE_W  payload of matching entry; 0 on miss.
- HIT_IDX  out  IDX_W  index of matching entry; 0 on miss.
- FILL_V  in  1  fill request.
- FILL_VPN  in  VPN_W  page being installed.
- FILL_PTE  in  PTE_W  payload being installed.
- FILL_READY  out  1  fill accepted when FILL_V && FILL_READY.
- INV_V  in  1  invalidate single page.
- INV_VPN  in  VPN_W  page to invalidate.
- FLUSH  in  1  start full flush; single-cycle pulse.
- BUSY  out  1  flush in progress.

Behaviour:
- Storage per entry:
  - valid bit, VPN tag, PTE payload.
  - Match condition: valid && tag == VPN.
  - Matches are one-hot because fill never creates duplicates. The priority encoder still selects the lowest index.
- Reset (asynchronous):
  - all valid bits 0; replacement pointer 0; FSM IDLE.
  - RESULT_V, HIT, HIT_PTE, HIT_IDX, BUSY all 0; FILL_READY 1.
  - Tags and payloads are not reset.
- Lookup:
  - Latency is 1 cycle. RESULT_V = LOOKUP_V delayed by one cycle.
  - HIT, HIT_PTE and HIT_IDX are registered. They hold their value when no lookup occurs.
  - A lookup sees array contents from before any write in the same cycle (read-before-write).
- FSM states: IDLE, FLUSHING.
- IDLE transitions:
  - FLUSH=1 → FLUSHING; flush counter cleared to 0.
  - Otherwise stay IDLE.
  - Same-cycle priority: FLUSH > INV_V > FILL. A lower-priority request is dropped, and FILL_READY is 0 that cycle.
- INV_V:
  - Clears the valid bit of the entry matching INV_VPN.
  - No match → no effect.
  - Replacement pointer unchanged.
- Fill (accepted when FILL_V && FILL_READY):
  - Victim selection, in order:
    1. Existing valid entry with tag == FILL_VPN → overwrite in place; pointer unchanged.
    2. Else the lowest-index invalid entry; pointer unchanged.
    3. Else the entry at the replacement pointer; pointer increments modulo NUM_ENTRIES.
  - The written entry gets valid=1, tag=FILL_VPN, payload=FILL_PTE.
- FLUSHING:
  - Clears the valid bit of entry[counter] each cycle, then the counter increments.
  - Exits to IDLE after clearing entry NUM_ENTRIES-1. The walk takes exactly NUM_ENTRIES cycles.
  - BUSY=1 and FILL_READY=0 throughout. FLUSH and INV_V are ignored.
  - Lookups are accepted and return HIT=0 regardless of contents.
  - Replacement pointer resets to 0 on flush exit.
- FILL_READY = (state==IDLE) && !FLUSH && !INV_V. It is combinational from the inputs.
- RST asserted mid-flush: immediate return to IDLE with all entries invalid.

Test Plan:
- After reset, fill VPN 20'h02000 / PTE 24'h00002E; lookup 20'h02000 next cycle → the following cycle RESULT_V=1, HIT=1, HIT_PTE=24'h00002E, HIT_IDX=0; lookup 20'h03000 → HIT=0, HIT_PTE=0.
- Fill 9 distinct VPNs 20'h00000..20'h00008 with NUM_ENTRIES=8 → entries 0..7 hold VPNs 0..7; the 9th fill evicts index 0 and the pointer becomes 1; lookup 20'h00000 misses and 20'h00008 hits at HIT_IDX=0.
- Refill VPN 20'h0b000 with new PTE 24'h00004E while it is already resident → same HIT_IDX as before, new payload returned, no second match, pointer unchanged.
- INV_V with 20'h0c000 resident at index 4, then fill 20'h0a000 into a full TLB → entry 4 is reused (lowest invalid), pointer unchanged; lookup 20'h0c000 misses.
- FLUSH pulse with 8 valid entries → BUSY=1 and FILL_READY=0 for 8 cycles; lookups during the walk return HIT=0; after BUSY falls every lookup misses and the next fill lands at index 0.
- Assert RST on the 3rd flush cycle → BUSY=0 and FILL_READY=1 immediately (asynchronously); all lookups miss; FLUSH asserted together with FILL_V and INV_V → neither the fill nor the invalidate is performed.

Source files
------------

// File: rtl/tlb_rw.sv
// Writable fully associative TLB: registered lookup, handshaked fill, single-page
// invalidate, one-entry-per-cycle flush walk and round-robin replacement.
module tlb_rw #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = 3,
  parameter int VPN_W       = 20,
  parameter int PTE_W       = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOOKUP_V,
  input  logic [VPN_W-1:0] LOOKUP_VPN,
  output logic             RESULT_V,
  output logic             HIT,
  output logic [PTE_W-1:0] HIT_PTE,
  output logic [IDX_W-1:0] HIT_IDX,
  input  logic             FILL_V,
  input  logic [VPN_W-1:0] FILL_VPN,
  input  logic [PTE_W-1:0] FILL_PTE,
  output logic             FILL_READY,
  input  logic             INV_V,
  input  logic [VPN_W-1:0] INV_VPN,
  input  logic             FLUSH,
  output logic             BUSY
);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       FLUSHING = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [VPN_W-1:0]       tag_mem_q [NUM_ENTRIES];
  logic [PTE_W-1:0]       pte_mem_q [NUM_ENTRIES];
  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;

  logic                   result_v_q;
  logic                   hit_q;
  logic [PTE_W-1:0]       hit_pte_q;
  logic [IDX_W-1:0]       hit_idx_q;

  logic [NUM_ENTRIES-1:0] lk_match_s, inv_match_s, fill_match_s;
  logic                   lk_hit_s;
  logic [IDX_W-1:0]       lk_idx_s, inv_idx_s, fill_idx_s, free_idx_s;
  logic                   wr_en_s;
  logic [IDX_W-1:0]       wr_idx_s;

  // Matches are one-hot in practice; the encoder still resolves to the lowest index.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_ENTRIES-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      lk_match_s[i]   = valid_q[i] && (tag_mem_q[i] == LOOKUP_VPN);
      inv_match_s[i]  = valid_q[i] && (tag_mem_q[i] == INV_VPN);
      fill_match_s[i] = valid_q[i] && (tag_mem_q[i] == FILL_VPN);
    end
  end

  assign lk_hit_s   = (state_q == IDLE) && (|lk_match_s);
  assign lk_idx_s   = lowest_idx(lk_match_s);
  assign inv_idx_s  = lowest_idx(inv_match_s);
  assign fill_idx_s = lowest_idx(fill_match_s);
  assign free_idx_s = lowest_idx(~valid_q);

  assign FILL_READY = (state_q == IDLE) && !FLUSH && !INV_V;

  // Control next state: FLUSH beats INV_V beats FILL while idle.
  always_comb begin
    valid_d  = valid_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    wr_en_s  = 1'b0;
    wr_idx_s = '0;
    case (state_q)
      IDLE: begin
        if (FLUSH) begin
          state_d = FLUSHING;
          cnt_d   = '0;
        end else if (INV_V) begin
          if (|inv_match_s) begin
            valid_d[inv_idx_s] = 1'b0;
          end
        end else if (FILL_V) begin
          wr_en_s = 1'b1;
          if (|fill_match_s) begin
            wr_idx_s = fill_idx_s;
          end else if (!(&valid_q)) begin
            wr_idx_s = free_idx_s;
          end else begin
            wr_idx_s = ptr_q;
            ptr_d    = ptr_q + IDX_W'(1);
          end
          valid_d[wr_idx_s] = 1'b1;
        end
      end
      FLUSHING: begin
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Tags and payloads carry no reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      tag_mem_q[wr_idx_s] <= FILL_VPN;
      pte_mem_q[wr_idx_s] <= FILL_PTE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result_v_q <= 1'b0;
      hit_q      <= 1'b0;
      hit_pte_q  <= '0;
      hit_idx_q  <= '0;
    end else begin
      result_v_q <= LOOKUP_V;
      if (LOOKUP_V) begin
        hit_q     <= lk_hit_s;
        hit_pte_q <= lk_hit_s ? pte_mem_q[lk_idx_s] : '0;
        hit_idx_q <= lk_hit_s ? lk_idx_s : '0;
      end
    end
  end

  assign RESULT_V = result_v_q;
  assign HIT      = hit_q;
  assign HIT_PTE  = hit_pte_q;
  assign HIT_IDX  = hit_idx_q;
  assign BUSY     = (state_q == FLUSHING);

endmodule

// File: tb/tb_tlb_rw.sv
// Self-checking bench for tlb_rw: lookup vectors checked through a scoreboard
// queue, plus directed sequences for flush, invalidate and mid-flush reset.
module tb_tlb_rw;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOOKUP_V = 1'b0;
  logic [19:0] LOOKUP_VPN = 20'h0;
  logic        RESULT_V;
  logic        HIT;
  logic [23:0] HIT_PTE;
  logic [2:0]  HIT_IDX;
  logic        FILL_V = 1'b0;
  logic [19:0] FILL_VPN = 20'h0;
  logic [23:0] FILL_PTE = 24'h0;
  logic        FILL_READY;
  logic        INV_V = 1'b0;
  logic [19:0] INV_VPN = 20'h0;
  logic        FLUSH = 1'b0;
  logic        BUSY;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [19:0] vpn;
    logic        hit;
    logic [23:0] pte;
    logic [2:0]  idx;
  } lk_t;

  lk_t exp_q[$];
  lk_t tbl[$];

  tlb_rw #(.NUM_ENTRIES(8), .IDX_W(3), .VPN_W(20), .PTE_W(24)) dut (
    .CLK(CLK), .RST(RST),
    .LOOKUP_V(LOOKUP_V), .LOOKUP_VPN(LOOKUP_VPN),
    .RESULT_V(RESULT_V), .HIT(HIT), .HIT_PTE(HIT_PTE), .HIT_IDX(HIT_IDX),
    .FILL_V(FILL_V), .FILL_VPN(FILL_VPN), .FILL_PTE(FILL_PTE), .FILL_READY(FILL_READY),
    .INV_V(INV_V), .INV_VPN(INV_VPN),
    .FLUSH(FLUSH), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic lk_t mk(input logic [19:0] vpn, input logic hit,
                             input logic [23:0] pte, input logic [2:0] idx);
    lk_t v;
    v.vpn = vpn; v.hit = hit; v.pte = pte; v.idx = idx;
    return v;
  endfunction

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    lk_t e;
    @(posedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk($sformatf("result_v vpn=%h", e.vpn), {31'd0, RESULT_V}, 32'd1);
      if (RESULT_V === 1'b1) begin
        chk($sformatf("hit vpn=%h", e.vpn), {31'd0, HIT}, {31'd0, e.hit});
        chk($sformatf("hit_pte vpn=%h", e.vpn), {8'd0, HIT_PTE}, {8'd0, e.pte});
        chk($sformatf("hit_idx vpn=%h", e.vpn), {29'd0, HIT_IDX}, {29'd0, e.idx});
      end
    end else if (RESULT_V !== 1'b0) begin
      chk("spurious result_v", {31'd0, RESULT_V}, 32'd0);
    end
  endtask

  task automatic lookup(input lk_t v);
    LOOKUP_V = 1'b1;
    LOOKUP_VPN = v.vpn;
    exp_q.push_back(v);
    step();
    LOOKUP_V = 1'b0;
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      lookup(tbl[i]);
    end
    tbl.delete();
  endtask

  task automatic fill(input logic [19:0] vpn, input logic [23:0] pte);
    FILL_V = 1'b1;
    FILL_VPN = vpn;
    FILL_PTE = pte;
    #1;
    chk($sformatf("fill_ready vpn=%h", vpn), {31'd0, FILL_READY}, 32'd1);
    step();
    FILL_V = 1'b0;
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  logic [19:0] set_vpn [8];
  int n;

  initial begin
    set_vpn = '{20'h01000, 20'h02000, 20'h03000, 20'h04000,
                20'h0c000, 20'h0b000, 20'h05000, 20'h06000};

    // Reset values
    step();
    step();
    chk("rst result_v", {31'd0, RESULT_V}, 32'd0);
    chk("rst hit", {31'd0, HIT}, 32'd0);
    chk("rst hit_pte", {8'd0, HIT_PTE}, 32'd0);
    chk("rst hit_idx", {29'd0, HIT_IDX}, 32'd0);
    chk("rst busy", {31'd0, BUSY}, 32'd0);
    chk("rst fill_ready", {31'd0, FILL_READY}, 32'd1);
    RST = 1'b0;

    // Basic fill then lookup, with hold when idle
    fill(20'h02000, 24'h00002E);
    tbl.push_back(mk(20'h02000, 1'b1, 24'h00002E, 3'd0));
    tbl.push_back(mk(20'h03000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h02000, 1'b1, 24'h00002E, 3'd0));
    run_tbl();
    step();
    chk("hold hit", {31'd0, HIT}, 32'd1);
    chk("hold hit_pte", {8'd0, HIT_PTE}, 32'h2E);

    // Nine fills: ninth evicts index 0, pointer moves to 1
    reset_dut();
    for (int i = 0; i < 9; i++) fill(20'(i), 24'h000100 + 24'(i));
    tbl.push_back(mk(20'h00000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h00008, 1'b1, 24'h000108, 3'd0));
    tbl.push_back(mk(20'h00001, 1'b1, 24'h000101, 3'd1));
    tbl.push_back(mk(20'h00007, 1'b1, 24'h000107, 3'd7));
    run_tbl();
    fill(20'h00009, 24'h000109);
    tbl.push_back(mk(20'h00009, 1'b1, 24'h000109, 3'd1));
    tbl.push_back(mk(20'h00001, 1'b0, 24'h0, 3'd0));
    run_tbl();

    // Refill of a resident page overwrites in place
    reset_dut();
    for (int i = 0; i < 8; i++) fill(set_vpn[i], 24'h000010 + 24'(i));
    fill(20'h0b000, 24'h00004E);
    tbl.push_back(mk(20'h0b000, 1'b1, 24'h00004E, 3'd5));
    run_tbl();

    // Invalidate with a same-cycle lookup that still sees the old entry
    INV_V = 1'b1;
    INV_VPN = 20'h0c000;
    #1;
    chk("fill_ready during inv", {31'd0, FILL_READY}, 32'd0);
    lookup(mk(20'h0c000, 1'b1, 24'h000014, 3'd4));
    INV_V = 1'b0;
    fill(20'h0a000, 24'h0000A1);
    fill(20'h0d000, 24'h0000D1);
    tbl.push_back(mk(20'h0c000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h0a000, 1'b1, 24'h0000A1, 3'd4));
    tbl.push_back(mk(20'h0d000, 1'b1, 24'h0000D1, 3'd0));
    tbl.push_back(mk(20'h01000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h0b000, 1'b1, 24'h00004E, 3'd5));
    run_tbl();

    // Flush walk: lookup in the FLUSH cycle sees old contents, then 8 busy cycles
    FLUSH = 1'b1;
    lookup(mk(20'h02000, 1'b1, 24'h000011, 3'd1));
    FLUSH = 1'b0;
    for (int k = 0; k < 8; k++) begin
      FILL_V = 1'b1;
      FILL_VPN = 20'h0e000;
      FILL_PTE = 24'h0000E1;
      LOOKUP_V = 1'b1;
      LOOKUP_VPN = 20'h03000;
      exp_q.push_back(mk(20'h03000, 1'b0, 24'h0, 3'd0));
      #1;
      chk($sformatf("busy walk %0d", k), {31'd0, BUSY}, 32'd1);
      chk($sformatf("fill_ready walk %0d", k), {31'd0, FILL_READY}, 32'd0);
      step();
    end
    FILL_V = 1'b0;
    LOOKUP_V = 1'b0;
    chk("busy after walk", {31'd0, BUSY}, 32'd0);
    chk("fill_ready after walk", {31'd0, FILL_READY}, 32'd1);
    tbl.push_back(mk(20'h0d000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h02000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h0b000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h0e000, 1'b0, 24'h0, 3'd0));
    run_tbl();
    fill(20'h0f000, 24'h0000F1);
    lookup(mk(20'h0f000, 1'b1, 24'h0000F1, 3'd0));

    // Reset asserted on the third flush cycle
    fill(20'h10000, 24'h000111);
    fill(20'h11000, 24'h000112);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    step();
    step();
    RST = 1'b1;
    #1;
    chk("mid-flush rst busy", {31'd0, BUSY}, 32'd0);
    chk("mid-flush rst fill_ready", {31'd0, FILL_READY}, 32'd1);
    chk("mid-flush rst result_v", {31'd0, RESULT_V}, 32'd0);
    step();
    RST = 1'b0;
    tbl.push_back(mk(20'h0f000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h10000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h11000, 1'b0, 24'h0, 3'd0));
    run_tbl();

    // INV_V beats a same-cycle fill
    fill(20'h12000, 24'h000121);
    INV_V = 1'b1;
    INV_VPN = 20'h12000;
    FILL_V = 1'b1;
    FILL_VPN = 20'h13000;
    FILL_PTE = 24'h000131;
    #1;
    chk("fill_ready inv+fill", {31'd0, FILL_READY}, 32'd0);
    step();
    INV_V = 1'b0;
    FILL_V = 1'b0;
    tbl.push_back(mk(20'h13000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h12000, 1'b0, 24'h0, 3'd0));
    run_tbl();

    // FLUSH beats same-cycle fill and invalidate
    fill(20'h12000, 24'h000122);
    FLUSH = 1'b1;
    FILL_V = 1'b1;
    FILL_VPN = 20'h14000;
    FILL_PTE = 24'h000141;
    INV_V = 1'b1;
    INV_VPN = 20'h12000;
    #1;
    chk("fill_ready flush+fill+inv", {31'd0, FILL_READY}, 32'd0);
    step();
    FLUSH = 1'b0;
    FILL_V = 1'b0;
    INV_V = 1'b0;
    n = 0;
    while (BUSY === 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("flush walk length", 32'(n), 32'd8);
    tbl.push_back(mk(20'h14000, 1'b0, 24'h0, 3'd0));
    tbl.push_back(mk(20'h12000, 1'b0, 24'h0, 3'd0));
    run_tbl();
    fill(20'h15000, 24'h000151);
    lookup(mk(20'h15000, 1'b1, 24'h000151, 3'd0));

    step();
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
